rgb_led_sched: RTL and testbench

Round-robin scheduler that shares the board's single RGB LED between N requesters. Each requester presents a colour and a blink flag, and holds a request line high. The block grants the LED to one requester at a time for a fixed slot measured in prescaled ticks. It drives redled/greenled/blueled directly and sits between the user-logic blocks and the LED pins, clocked from the on-chip system clock.

---
 rtl/rgb_led_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_rgb_led_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sched.sv
// rgb_led_sched: round-robin owner of the single board RGB LED.
// N requesters hold req high; each granted owner shows its colour for
// SLOT_TICKS prescaled ticks, then ownership rotates to the next index.
// Optional build macro: LED_BLINK_EN (honours the per-requester blink
// input; without it the owner's colour is shown steadily for the slot).
module rgb_led_sched #(
  parameter int N          = 3,
  parameter int TICK_DIV   = 2000000,
  parameter int SLOT_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [3*N-1:0]   color,
  input  logic [N-1:0]     blink,
  output logic [N-1:0]     grant,
  output logic             done,
  output logic             busy,
  output logic             redled,
  output logic             greenled,
  output logic             blueled
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(SLOT_TICKS + 1);
  localparam int IW = $clog2(N);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Next requester index with an explicit wrap at N-1.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    if (i == IDX_LAST) begin
      return '0;
    end else begin
      return i + IW'(1);
    end
  endfunction

  // One-hot vector for a requester index.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] oh;
    oh = '0;
    for (int j = 0; j < N; j++) begin
      oh[j] = (IW'(j) == i);
    end
    return oh;
  endfunction

  // {r,g,b} triple of requester i from the packed colour bus.
  function automatic logic [2:0] color_of(input logic [3*N-1:0] cv,
                                          input logic [IW-1:0]  i);
    logic [2:0] c;
    c = 3'b000;
    for (int j = 0; j < N; j++) begin
      if (IW'(j) == i) begin
        c = cv[3*j +: 3];
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   presc_r;
  logic            tick_s;
  logic [IW-1:0]   ptr_r, ptr_nxt_s;
  logic [IW-1:0]   own_r, own_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [N-1:0]    grant_r, grant_nxt_s;
  logic            done_r, done_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic [2:0]      led_r, led_nxt_s;
  logic            phase_nxt_s;
  logic            found_s;
  logic [IW-1:0]   sel_s;
  logic [IW-1:0]   walk_s;

  // Free-running prescaler, wraps at TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick_s = (presc_r == PRESC_LAST);

  // Rotating-priority search: first requester at or after ptr.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    walk_s  = ptr_r;
    for (int k = 0; k < N; k++) begin
      if (!found_s && req[walk_s]) begin
        found_s = 1'b1;
        sel_s   = walk_s;
      end else begin
        sel_s   = sel_s;
      end
      walk_s = idx_inc(walk_s);
    end
  end

`ifdef LED_BLINK_EN
  logic phase_r;

  // Blink phase: lit at grant, flips on each tick of a blinking owner.
  always_comb begin
    phase_nxt_s = phase_r;
    if (state_r == ARB) begin
      phase_nxt_s = 1'b1;
    end else if ((state_r == SHOW) && tick_s && blink[own_r]) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b1;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end
`else
  logic unused_blink_s;

  // Steady display: the owner's colour is lit for the whole slot.
  assign phase_nxt_s    = 1'b1;
  assign unused_blink_s = ^blink;
`endif

  // State register of the IDLE/ARB/SHOW controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    own_nxt_s   = own_r;
    cnt_nxt_s   = cnt_r;
    grant_nxt_s = '0;
    done_nxt_s  = 1'b0;
    busy_nxt_s  = 1'b0;
    led_nxt_s   = 3'b000;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARB: begin
        if (found_s) begin
          own_nxt_s   = sel_s;
          cnt_nxt_s   = '0;
          grant_nxt_s = onehot(sel_s);
          busy_nxt_s  = 1'b1;
          led_nxt_s   = color_of(color, sel_s) & {3{phase_nxt_s}};
          state_nxt_s = SHOW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHOW: begin
        if (!req[own_r]) begin
          // Owner let go: abandon wins over a coincident slot end.
          ptr_nxt_s   = idx_inc(own_r);
          state_nxt_s = ARB;
        end else if (tick_s && (cnt_r == CNT_LAST)) begin
          done_nxt_s  = 1'b1;
          ptr_nxt_s   = idx_inc(own_r);
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = SHOW;
          grant_nxt_s = grant_r;
          busy_nxt_s  = 1'b1;
          led_nxt_s   = color_of(color, own_r) & {3{phase_nxt_s}};
          if (tick_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= '0;
      own_r   <= '0;
      cnt_r   <= '0;
      grant_r <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      led_r   <= 3'b000;
    end else begin
      ptr_r   <= ptr_nxt_s;
      own_r   <= own_nxt_s;
      cnt_r   <= cnt_nxt_s;
      grant_r <= grant_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
      led_r   <= led_nxt_s;
    end
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign redled   = led_r[2];
  assign greenled = led_r[1];
  assign blueled  = led_r[0];

endmodule

// File: tb/tb_rgb_led_sched.sv
// Bench for rgb_led_sched (N=3, TICK_DIV=4, SLOT_TICKS=3): directed
// traces with literal expectations plus a long random run checked every
// cycle against a behavioural model of the scheduler.
module tb_rgb_led_sched;

  localparam int TN = 3;
  localparam int TD = 4;
  localparam int TS = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [8:0]  color;
  logic [2:0]  blink;
  logic [2:0]  grant;
  logic        done;
  logic        busy;
  logic        redled;
  logic        greenled;
  logic        blueled;

  int tests = 0;
  int fails = 0;

  rgb_led_sched #(.N(TN), .TICK_DIV(TD), .SLOT_TICKS(TS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .color    (color),
    .blink    (blink),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .redled   (redled),
    .greenled (greenled),
    .blueled  (blueled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] col(input int i);
    return color[3*i +: 3];
  endfunction

  // Behavioural model: mode 0 idle, 1 arbitrating, 2 showing.
  int         m_mode, m_ptr, m_owner, m_ticks, m_flips, m_cyc;
  logic [2:0] e_grant, e_led;
  logic       e_done, e_busy;

  // Model step for the clock edge just passed, then compare with the DUT.
  always @(negedge clk) begin : model_cmp
    int g;
    bit tk;
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_owner = 0; m_ticks = 0; m_flips = 0; m_cyc = 0;
      e_grant = 3'b000; e_led = 3'b000; e_done = 1'b0; e_busy = 1'b0;
    end else begin
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      e_grant = 3'b000; e_led = 3'b000; e_done = 1'b0; e_busy = 1'b0;
      if (m_mode == 0) begin
        if (req != 3'b000) m_mode = 1;
      end else if (m_mode == 1) begin
        g = -1;
        for (int k = 0; k < TN; k++)
          if (g < 0 && req[(m_ptr + k) % TN]) g = (m_ptr + k) % TN;
        if (g < 0) begin
          m_mode = 0;
        end else begin
          m_owner = g; m_ticks = 0; m_flips = 0; m_mode = 2;
          e_grant = 3'(1 << g); e_busy = 1'b1; e_led = col(g);
        end
      end else begin
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % TN; m_mode = 1;
        end else if (tk && m_ticks == TS - 1) begin
          e_done = 1'b1; m_ptr = (m_owner + 1) % TN; m_mode = 1;
        end else begin
          if (tk) begin
            m_ticks++;
`ifdef LED_BLINK_EN
            if (blink[m_owner]) m_flips++;
`endif
          end
          e_grant = 3'(1 << m_owner); e_busy = 1'b1;
          e_led = (m_flips % 2 == 0) ? col(m_owner) : 3'b000;
        end
      end
    end
    check("model grant", grant, e_grant);
    check("model done", done, e_done);
    check("model busy", busy, e_busy);
    check("model led", {redled, greenled, blueled}, e_led);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_with(input logic [2:0] r, input logic [8:0] c, input logic [2:0] b);
    @(negedge clk);
    #2;
    rst_n = 1'b0; req = r; color = c; blink = b;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [2:0] rr_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] rr_led[4] = '{3'b100, 3'b010, 3'b001, 3'b100};
  logic [2:0] seen[$];
  logic [2:0] seen_led[$];
  logic [2:0] prev;
  int         dones;
  int         nseen;

  initial begin
    rst_n = 1'b0; req = 3'b000; color = 9'h000; blink = 3'b000;
    @(negedge clk);
    check("reset grant", grant, 3'b000);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);

    // Single requester, steady red.
    reset_with(3'b001, 9'b000_000_100, 3'b000);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 1)  check("single arb grant", grant, 3'b000);
      if (k == 2)  check("single grant", grant, 3'b001);
      if (k == 2)  check("single led", {redled, greenled, blueled}, 3'b100);
      if (k == 2)  check("single busy", busy, 1'b1);
      if (k == 11) check("single pre-done", done, 1'b0);
      if (k == 12) check("single done", done, 1'b1);
      if (k == 12) check("single dark", {grant, redled, greenled, blueled}, 6'b000_000);
      if (k == 13) check("single regrant", grant, 3'b001);
      if (k == 13) check("single done clr", done, 1'b0);
    end

    // Reset in the middle of a slot clears outputs at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0; req = 3'b000;
    #1;
    check("midreset grant", grant, 3'b000);
    check("midreset busy", busy, 1'b0);
    check("midreset led", {redled, greenled, blueled}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("post-reset idle grant", grant, 3'b000);
    check("post-reset idle busy", busy, 1'b0);

    // Blinking white.
    reset_with(3'b001, 9'b000_000_111, 3'b001);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 3) check("blink first period", {redled, greenled, blueled}, 3'b111);
`ifdef LED_BLINK_EN
      if (k == 4) check("blink off", {redled, greenled, blueled}, 3'b000);
      if (k == 7) check("blink still off", {redled, greenled, blueled}, 3'b000);
`else
      if (k == 4) check("steady on", {redled, greenled, blueled}, 3'b111);
      if (k == 7) check("steady still on", {redled, greenled, blueled}, 3'b111);
`endif
      if (k == 8)  check("blink on again", {redled, greenled, blueled}, 3'b111);
      if (k == 12) check("blink done", done, 1'b1);
    end

    // Round-robin over all three requesters.
    reset_with(3'b111, 9'b001_010_100, 3'b000);
    prev = 3'b000; dones = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (grant != 3'b000 && prev == 3'b000) begin
        seen.push_back(grant);
        seen_led.push_back({redled, greenled, blueled});
      end
      if (done) dones++;
      prev = grant;
    end
    nseen = seen.size();
    check("rr grant count", nseen, 4);
    check("rr done count", dones, 3);
    while (seen.size() < 4) begin
      seen.push_back(3'b000);
      seen_led.push_back(3'b000);
    end
    for (int i = 0; i < 4; i++) begin
      check("rr order", seen[i], rr_exp[i]);
      check("rr colour", seen_led[i], rr_led[i]);
    end

    // Abandon: requester 0 lets go after its first tick.
    reset_with(3'b011, 9'b000_010_100, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 2) check("abandon first grant", grant, 3'b001);
      if (k == 4) req = 3'b010;
      if (k == 5) check("abandon grant off", grant, 3'b000);
      if (k == 5) check("abandon no done", done, 1'b0);
      if (k == 6) check("abandon next grant", grant, 3'b010);
      if (k == 6) check("abandon next led", {redled, greenled, blueled}, 3'b010);
    end

    // Random traffic against the model.
    reset_with(3'($urandom_range(0, 7)), 9'($urandom), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 11) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) color = 9'($urandom);
      if ($urandom_range(0, 5) == 0) blink = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
